// File: rtl/mat_op_pipe.sv
//==============================================================================
// Module   : mat_op_pipe
// Brief    : Pipelined NxN signed matrix MUL/ADD/SUB/HADAMARD unit, valid/ready
//            handshake with full backpressure. Define MAT_OP_SAT_EN to clamp
//            results to W_OUT instead of two's-complement wrap.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mat_op_pipe #(
  parameter int W_IN  = 8,
  parameter int W_OUT = 32,
  parameter int N     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cen,
  input  logic                    valid_in,
  output logic                    ready_in,
  input  logic [1:0]              mode,
  input  logic signed [W_IN-1:0]  matrix_1 [N][N],
  input  logic signed [W_IN-1:0]  matrix_2 [N][N],
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic signed [W_OUT-1:0] result [N][N],
  output logic [1:0]              mode_out,
  output logic                    busy
);

  localparam int         c_DEPTH    = $clog2(N);
  localparam int         c_W_INT    = 2*W_IN + c_DEPTH + 1;
  localparam logic [1:0] c_MODE_MUL = 2'b00;
  localparam logic [1:0] c_MODE_ADD = 2'b01;
  localparam logic [1:0] c_MODE_SUB = 2'b10;

  logic signed [c_W_INT-1:0] r_lane [c_DEPTH+1][N][N][N];
  logic signed [c_W_INT-1:0] w_tree [c_DEPTH+1][N][N][N];
  logic signed [c_W_INT-1:0] w_prod [N][N][N];
  logic signed [W_OUT-1:0]   w_conv [N][N];
  logic [1:0]                r_mode [c_DEPTH+1];
  logic [c_DEPTH:0]          r_vld;
  logic                      w_stall;
  logic                      w_adv;
  logic                      w_acc;

  assign w_stall  = valid_out && !ready_out;
  assign w_adv    = cen && !w_stall;
  assign ready_in = cen && !w_stall && !rst;
  assign w_acc    = valid_in && ready_in;
  assign busy     = (|r_vld) || valid_out;

  // Operands are gated by w_acc so idle-cycle garbage never reaches the tree.
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        for (int k = 0; k < N; k++) begin
          w_prod[r][c][k] = '0;
          if (w_acc) begin
            if (mode == c_MODE_MUL) begin
              w_prod[r][c][k] = c_W_INT'(matrix_1[r][k]) * c_W_INT'(matrix_2[k][c]);
            end else if (k == 0) begin
              case (mode)
                c_MODE_ADD: w_prod[r][c][k] = c_W_INT'(matrix_1[r][c]) + c_W_INT'(matrix_2[r][c]);
                c_MODE_SUB: w_prod[r][c][k] = c_W_INT'(matrix_1[r][c]) - c_W_INT'(matrix_2[r][c]);
                default:    w_prod[r][c][k] = c_W_INT'(matrix_1[r][c]) * c_W_INT'(matrix_2[r][c]);
              endcase
            end
          end
        end
      end
    end
  end

  // Lane i folds into lane i/2; an odd leftover lane simply adds to zero.
  always_comb begin
    for (int s = 0; s <= c_DEPTH; s++) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          for (int j = 0; j < N; j++) begin
            w_tree[s][r][c][j] = '0;
          end
          for (int i = 0; i < N; i++) begin
            w_tree[s][r][c][i/2] = w_tree[s][r][c][i/2] + r_lane[s][r][c][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld     <= '0;
      valid_out <= 1'b0;
      mode_out  <= '0;
      for (int s = 0; s <= c_DEPTH; s++) begin
        r_mode[s] <= '0;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            for (int k = 0; k < N; k++)
              r_lane[s][r][c][k] <= '0;
      end
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          result[r][c] <= '0;
    end else if (w_adv) begin
      r_vld[0]  <= w_acc;
      r_mode[0] <= w_acc ? mode : 2'b00;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          for (int k = 0; k < N; k++)
            r_lane[0][r][c][k] <= w_prod[r][c][k];
      for (int s = 1; s <= c_DEPTH; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_mode[s] <= r_mode[s-1];
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            for (int k = 0; k < N; k++)
              r_lane[s][r][c][k] <= w_tree[s-1][r][c][k];
      end
      valid_out <= r_vld[c_DEPTH];
      mode_out  <= r_mode[c_DEPTH];
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          result[r][c] <= w_conv[r][c];
    end
  end

  generate
    if (W_OUT >= c_W_INT) begin : g_extend
      always_comb begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            w_conv[r][c] = W_OUT'(r_lane[c_DEPTH][r][c][0]);
      end
    end else begin : g_narrow
`ifdef MAT_OP_SAT_EN
      localparam logic signed [c_W_INT-1:0] c_MAX = c_W_INT'((64'sd1 <<< (W_OUT-1)) - 64'sd1);
      localparam logic signed [c_W_INT-1:0] c_MIN = ~c_MAX;
      always_comb begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++) begin
            if (r_lane[c_DEPTH][r][c][0] > c_MAX)
              w_conv[r][c] = W_OUT'(c_MAX);
            else if (r_lane[c_DEPTH][r][c][0] < c_MIN)
              w_conv[r][c] = W_OUT'(c_MIN);
            else
              w_conv[r][c] = r_lane[c_DEPTH][r][c][0][W_OUT-1:0];
          end
        end
      end
`else
      always_comb begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++)
            w_conv[r][c] = r_lane[c_DEPTH][r][c][0][W_OUT-1:0];
      end
`endif
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mat_op_pipe.sv
//==============================================================================
// Module   : tb_mat_op_pipe
// Brief    : Self-checking bench for mat_op_pipe (32-bit and 16-bit result
//            instances) against a queue-based behavioural model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mat_op_pipe;

  logic clk = 1'b0;
  logic rst, cen, valid_in, ready_out;
  logic [1:0] mode;
  logic signed [7:0] m1 [4][4];
  logic signed [7:0] m2 [4][4];

  logic ready_in, valid_out, busy;
  logic [1:0] mode_out;
  logic signed [31:0] result [4][4];
  logic ready_in16, valid_out16, busy16;
  logic [1:0] mode_out16;
  logic signed [15:0] result16 [4][4];

  int checks = 0;
  int errors = 0;
  int pops   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [1:0]        md;
    logic [15:0][31:0] m;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  mat_op_pipe #(.W_IN(8), .W_OUT(32), .N(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in), .ready_in(ready_in),
    .mode(mode), .matrix_1(m1), .matrix_2(m2), .valid_out(valid_out),
    .ready_out(ready_out), .result(result), .mode_out(mode_out), .busy(busy)
  );

  mat_op_pipe #(.W_IN(8), .W_OUT(16), .N(4)) dut16 (
    .clk(clk), .rst(rst), .cen(cen), .valid_in(valid_in), .ready_in(ready_in16),
    .mode(mode), .matrix_1(m1), .matrix_2(m2), .valid_out(valid_out16),
    .ready_out(ready_out), .result(result16), .mode_out(mode_out16), .busy(busy16)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic int conv16(input int v);
`ifdef MAT_OP_SAT_EN
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
`else
    return int'(shortint'(v));
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] md,
                                 input logic signed [7:0] a [4][4],
                                 input logic signed [7:0] b [4][4]);
    exp_t e;
    int   acc;
    e.md = md;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        acc = 0;
        case (md)
          2'b00: for (int k = 0; k < 4; k++) acc += int'(a[r][k]) * int'(b[k][c]);
          2'b01: acc = int'(a[r][c]) + int'(b[r][c]);
          2'b10: acc = int'(a[r][c]) - int'(b[r][c]);
          default: acc = int'(a[r][c]) * int'(b[r][c]);
        endcase
        e.m[r*4+c] = acc;
      end
    end
    return e;
  endfunction

  // Every cycle: handshake rule, occupancy, and head-of-queue result compare.
  always @(negedge clk) begin : mon
    exp_t h;
    int   bi;
    int   b16;
    if (mon_en) begin
      chk("ready_in", ready_in, cen && !(valid_out && !ready_out) && !rst);
      chk("ready_in16", ready_in16, cen && !(valid_out && !ready_out) && !rst);
      chk("busy", busy, q.size() != 0);
      chk("busy16", busy16, q.size() != 0);
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_out", valid_out, 0);
        end else begin
          h = q[0];
          bi = 0;
          b16 = 0;
          for (int i = 15; i >= 0; i--) begin
            if (int'(result[i/4][i%4]) != int'(h.m[i])) bi = i;
            if (int'(result16[i/4][i%4]) != conv16(int'(h.m[i]))) b16 = i;
          end
          chk("model_result", result[bi/4][bi%4], int'(h.m[bi]));
          chk("model_result16", result16[b16/4][b16%4], conv16(int'(h.m[b16])));
          chk("model_mode", mode_out, h.md);
          chk("model_mode16", mode_out16, h.md);
          chk("model_valid16", valid_out16, 1);
          if (ready_out && cen && !rst) begin
            void'(q.pop_front());
            pops++;
          end
        end
      end
      if (rst) q.delete();
      else if (valid_in && cen && !(valid_out && !ready_out)) q.push_back(model(mode, m1, m2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic signed [7:0] a, input logic signed [7:0] b);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m1[r][c] = a;
        m2[r][c] = b;
      end
  endtask

  task automatic rand_mats();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m1[r][c] = 8'($urandom);
        m2[r][c] = 8'($urandom);
      end
  endtask

  task automatic send(input logic [1:0] md);
    bit acc;
    int n;
    n = 0;
    valid_in = 1'b1;
    mode = md;
    do begin
      @(negedge clk);
      acc = ready_in;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 50);
    valid_in = 1'b0;
    chk("send_accept", acc, 1);
  endtask

  task automatic chk_mat(input string nm, input int v32, input int v16, input logic [1:0] md);
    for (int i = 0; i < 16; i++) begin
      chk(nm, result[i/4][i%4], v32);
      chk({nm, "_w16"}, result16[i/4][i%4], v16);
    end
    chk({nm, "_mode"}, mode_out, md);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    int n;
    rst = 1'b1; cen = 1'b1; valid_in = 1'b1; ready_out = 1'b1; mode = 2'b00;
    rand_mats();
    // Reset held with valid_in asserted
    step();
    mon_en = 1'b1;
    step();
    chk("rst_ready_in", ready_in, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_busy", busy, 0);
    chk_mat("rst_result", 0, 0, 2'b00);
    rst = 1'b0;
    valid_in = 1'b0;
    step();

    // Identity times B: B reappears after exactly three edges
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m1[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        m2[r][c] = 8'(4*r + c);
      end
    send(2'b00);
    for (int i = 0; i <= 3; i++) begin
      chk("mul_latency_valid", valid_out, i == 3);
      if (i < 3) step();
    end
    for (int i = 0; i < 16; i++) chk("mul_identity", result[i/4][i%4], i);
    chk("mul_identity_mode", mode_out, 0);
    repeat (3) step();

    // Back-to-back ADD / SUB / HADAMARD
    fill(8'sd5, -8'sd3);
    send(2'b01);
    send(2'b10);
    fill(-8'sd2, 8'sd7);
    send(2'b11);
    step(); chk_mat("b2b_add", 2, 2, 2'b01);
    step(); chk_mat("b2b_sub", 8, 8, 2'b10);
    step(); chk_mat("b2b_had", -14, -14, 2'b11);
    repeat (3) step();
    chk("b2b_idle_busy", busy, 0);

    // 16-bit output: saturate or wrap
    fill(8'sd127, 8'sd127);
    send(2'b00);
    repeat (3) step();
`ifdef MAT_OP_SAT_EN
    chk_mat("w16_mul", 64516, 32767, 2'b00);
`else
    chk_mat("w16_mul", 64516, -1020, 2'b00);
`endif
    repeat (3) step();

    // Backpressure: 4-cycle stall from first valid_out
    p0 = pops;
    fork
      begin
        for (int b = 0; b < 6; b++) begin
          rand_mats();
          send(2'b00);
        end
      end
      begin
        n = 0;
        while (!valid_out && n < 30) begin
          step();
          n++;
        end
        chk("bp_first_valid", valid_out, 1);
        ready_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_ready_in", ready_in, 0);
          chk("bp_valid_held", valid_out, 1);
          step();
        end
        ready_out = 1'b1;
      end
    join
    repeat (8) step();
    chk("bp_result_count", pops - p0, 6);
    chk("bp_drained", q.size(), 0);

    // cen freeze mid-stream, then rst with two beats in flight
    rand_mats(); send(2'b01);
    rand_mats(); send(2'b11);
    cen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cen_ready_in", ready_in, 0);
      chk("cen_valid_out", valid_out, 0);
      chk("cen_busy", busy, 1);
      step();
    end
    cen = 1'b1;
    step(); chk("cen_resume_early", valid_out, 0);
    step(); chk("cen_resume_valid", valid_out, 1);
    repeat (4) step();
    rand_mats(); send(2'b00);
    rand_mats(); send(2'b10);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid_out", valid_out, 0);
    chk("rst_mid_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst_no_stale", valid_out, 0);
    end

    // Randomised traffic
    for (int t = 0; t < 400; t++) begin
      valid_in  = ($urandom_range(0, 9) < 7);
      mode      = 2'($urandom);
      rand_mats();
      ready_out = ($urandom_range(0, 3) != 0);
      cen       = ($urandom_range(0, 9) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; cen = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    repeat (8) step();
    chk("rand_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
